// File: rtl/axi_ahb_pkg.sv
// rtl/axi_ahb_pkg.sv - shared types and constants for the AXI-to-AHB bridge
package axi_ahb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        GRANT = 3'b010,
        BUSY  = 3'b100
    } arb_state_t;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    localparam int REQ_WR = 0;
    localparam int REQ_RD = 1;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-base priority picker
module rr_pick #(
    parameter int N   = 2,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_base,
    output logic [N-1:0]   o_onehot,
    output logic [IDW-1:0] o_id,
    output logic           o_valid
);

    // Two passes: indices at or above base first, then the wrapped-around low indices.
    always_comb begin
        o_onehot = '0;
        o_id     = '0;
        o_valid  = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!o_valid && i_req[j] && (j >= int'(i_base))) begin
                o_valid     = 1'b1;
                o_onehot[j] = 1'b1;
                o_id        = IDW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!o_valid && i_req[j] && (j < int'(i_base))) begin
                o_valid     = 1'b1;
                o_onehot[j] = 1'b1;
                o_id        = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/axi_ahb_req_arbiter.sv
// rtl/axi_ahb_req_arbiter.sv - N-way request arbiter in front of the AHB master engine
module axi_ahb_req_arbiter
    import axi_ahb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 256,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               ack,
    input  logic               done,
    output logic [NUM_REQ-1:0] start,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id,
    output logic               busy,
    output logic               timeout
);

    arb_state_t         r_state;
    arb_state_t         w_next;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDW-1:0]     r_grant_id;
    logic               r_timeout;
    logic [NUM_REQ-1:0] w_win;
    logic [IDW-1:0]     w_win_id;
    logic [IDW-1:0]     w_base;
    logic               w_win_valid;
    logic               w_expire;
    logic               w_take;
    logic               w_release;

    assign w_take    = (r_state == IDLE) && ack && w_win_valid;
    assign w_release = (r_state == BUSY) && (done || w_expire);

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_pick (
        .i_req    (req),
        .i_base   (w_base),
        .o_onehot (w_win),
        .o_id     (w_win_id),
        .o_valid  (w_win_valid)
    );

    generate
        if (PRIO_MODE == PRIO_FIXED) begin : g_fixed
            assign w_base = '0;
        end else begin : g_rr
            logic [IDW-1:0] r_last_id;
            // Resetting to the top index makes requester 0 win the first contest.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_last_id <= IDW'(NUM_REQ - 1);
                end else if (w_take) begin
                    r_last_id <= w_win_id;
                end
            end
            assign w_base = (r_last_id == IDW'(NUM_REQ - 1)) ? '0 : r_last_id + IDW'(1);
        end
    endgenerate

    generate
        if (TIMEOUT == 0) begin : g_no_wdog
            assign w_expire = 1'b0;
        end else begin : g_wdog
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] r_cnt;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt <= '0;
                end else if (r_state == GRANT) begin
                    r_cnt <= '0;
                end else if (r_state == BUSY) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            assign w_expire = (r_state == BUSY) && (r_cnt == CW'(TIMEOUT - 1));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_take) w_next = GRANT;
            GRANT:   w_next = BUSY;
            BUSY:    if (done || w_expire) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // done wins over a coincident expiry, so timeout only fires when done is absent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant    <= '0;
            r_grant_id <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_expire && !done;
            if (w_take) begin
                r_grant    <= w_win;
                r_grant_id <= w_win_id;
            end else if (w_release) begin
                r_grant    <= '0;
                r_grant_id <= '0;
            end
        end
    end

    always_comb begin
        start    = (r_state == GRANT) ? r_grant : '0;
        busy     = (r_state != IDLE);
        grant    = r_grant;
        grant_id = r_grant_id;
        timeout  = r_timeout;
    end

endmodule
